// File: rtl/rect_sequence_drawer_pkg.sv
// Shared constants for the rectangle sequence drawer: FSM state codes,
// default widths and the descriptor skip test.
package rect_draw_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_DRAW = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int DEF_NUM_RECTS = 4;
    localparam int DEF_X_W       = 8;
    localparam int DEF_Y_W       = 7;
    localparam int DEF_COLOUR_W  = 3;
    localparam int DEF_IDX_W     = 4;

    // A descriptor with zero width or zero height contributes no pixels.
    function automatic logic is_skip(input logic w_zero, input logic h_zero);
        return w_zero | h_zero;
    endfunction

endpackage

// File: rtl/rect_sequence_drawer_if.sv
// Descriptor-table and pixel-stream bus of the rectangle sequence drawer.
// RECT_OUTLINE_EN adds the per-descriptor desc_outline bit.
interface rect_sequence_drawer_if
    import rect_draw_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int IDX_W    = DEF_IDX_W
);
    // start is a level request sampled only while idle; plot is a valid
    // qualifier for x/y/colour with no backpressure (the sink always accepts).
    // desc_* answer desc_idx and must hold from an index change through LOAD.
    logic                start;
    logic [IDX_W-1:0]    desc_idx;
    logic [X_W-1:0]      desc_x0;
    logic [Y_W-1:0]      desc_y0;
    logic [X_W-1:0]      desc_w;
    logic [Y_W-1:0]      desc_h;
    logic [COLOUR_W-1:0] desc_colour;
`ifdef RECT_OUTLINE_EN
    logic                desc_outline;
`endif
    logic                plot;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                busy;
    logic                finish;
    logic [2:0]          dbg_state;

    modport master (
        input  start, desc_x0, desc_y0, desc_w, desc_h, desc_colour,
`ifdef RECT_OUTLINE_EN
        input  desc_outline,
`endif
        output desc_idx, plot, x, y, colour, busy, finish, dbg_state
    );

    modport slave (
        output start, desc_x0, desc_y0, desc_w, desc_h, desc_colour,
`ifdef RECT_OUTLINE_EN
        output desc_outline,
`endif
        input  desc_idx, plot, x, y, colour, busy, finish, dbg_state
    );

endinterface

// File: rtl/rect_sequence_drawer_raster.sv
// Row-major dx/dy raster counter. Presents the coordinates of the pixel that
// follows the current one so the owner can register outputs a cycle early.
module rect_raster_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           load,
    input  logic           enable,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] dx_next,
    output logic [Y_W-1:0] dy_next,
    output logic           last
);
    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    logic           row_end;

    assign row_end = (dx == w - X_ONE);
    assign last    = row_end && (dy == h - Y_ONE);
    assign dx_next = row_end ? '0 : dx + X_ONE;
    assign dy_next = row_end ? dy + Y_ONE : dy;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (load) begin
            dx <= '0;
            dy <= '0;
        end else if (enable) begin
            dx <= dx_next;
            dy <= dy_next;
        end
    end

endmodule

// File: rtl/rect_sequence_drawer.sv
// Walks NUM_RECTS descriptors and streams each rectangle as row-major pixels.
// Build with RECT_OUTLINE_EN to allow border-only rectangles.
module rect_sequence_drawer
    import rect_draw_pkg::*;
#(
    parameter int NUM_RECTS = DEF_NUM_RECTS,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int COLOUR_W  = DEF_COLOUR_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                   clock,
    input  logic                   resetn,
    rect_sequence_drawer_if.master bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RECTS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [IDX_W-1:0]    idx_r;
    logic [X_W-1:0]      x0_r;
    logic [Y_W-1:0]      y0_r;
    logic [X_W-1:0]      w_r;
    logic [Y_W-1:0]      h_r;
    logic [COLOUR_W-1:0] col_r;
    logic                plot_r;
    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;
    logic [COLOUR_W-1:0] colour_r;
    logic                busy_r;
    logic                finish_r;

    logic [X_W-1:0]      dx_next;
    logic [Y_W-1:0]      dy_next;
    logic                last;
    logic                skip;
    logic                pix_on;

    assign skip = is_skip(bus.desc_w == '0, bus.desc_h == '0);

    rect_raster_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_raster (
        .clock   (clock),
        .resetn  (resetn),
        .load    (state == ST_LOAD),
        .enable  (state == ST_DRAW),
        .w       (w_r),
        .h       (h_r),
        .dx_next (dx_next),
        .dy_next (dy_next),
        .last    (last)
    );

`ifdef RECT_OUTLINE_EN
    logic outline_r;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            outline_r <= 1'b0;
        else if (state == ST_LOAD)
            outline_r <= bus.desc_outline;
    end

    // Interior pixels still take a cycle; only the plot strobe is masked.
    assign pix_on = !outline_r
                 || (dx_next == '0) || (dx_next == w_r - X_W'(1))
                 || (dy_next == '0) || (dy_next == h_r - Y_W'(1));
`else
    assign pix_on = 1'b1;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_LOAD;
            ST_LOAD: state_next = skip ? ST_NEXT : ST_DRAW;
            ST_DRAW: if (last) state_next = ST_NEXT;
            ST_NEXT: state_next = (idx_r == LAST_IDX) ? ST_DONE : ST_LOAD;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            idx_r    <= '0;
            x0_r     <= '0;
            y0_r     <= '0;
            w_r      <= '0;
            h_r      <= '0;
            col_r    <= '0;
            plot_r   <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= '0;
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
        end else begin
            state    <= state_next;
            busy_r   <= (state_next != ST_IDLE);
            finish_r <= (state_next == ST_DONE);
            plot_r   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) idx_r <= '0;
                end
                ST_LOAD: begin
                    x0_r  <= bus.desc_x0;
                    y0_r  <= bus.desc_y0;
                    w_r   <= bus.desc_w;
                    h_r   <= bus.desc_h;
                    col_r <= bus.desc_colour;
                    // Top-left pixel goes out straight from the descriptor
                    // so the first plot lands in the cycle after LOAD.
                    if (!skip) begin
                        plot_r   <= 1'b1;
                        x_r      <= bus.desc_x0;
                        y_r      <= bus.desc_y0;
                        colour_r <= bus.desc_colour;
                    end
                end
                ST_DRAW: begin
                    if (!last) begin
                        plot_r   <= pix_on;
                        x_r      <= x0_r + dx_next;
                        y_r      <= y0_r + dy_next;
                        colour_r <= col_r;
                    end
                end
                ST_NEXT: begin
                    if (idx_r != LAST_IDX) idx_r <= idx_r + IDX_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.desc_idx  = idx_r;
    assign bus.plot      = plot_r;
    assign bus.x         = x_r;
    assign bus.y         = y_r;
    assign bus.colour    = colour_r;
    assign bus.busy      = busy_r;
    assign bus.finish    = finish_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_rect_sequence_drawer.sv
// Self-checking bench for rect_sequence_drawer: a per-cycle reference model
// for a four-descriptor drawer plus directed checks on a one-descriptor drawer.
module tb_rect_sequence_drawer;

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       busy;
        logic       finish;
        logic [3:0] idx;
    } exp_t;

    localparam int NR = 4;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic [7:0] tab_x0  [16];
    logic [6:0] tab_y0  [16];
    logic [7:0] tab_w   [16];
    logic [6:0] tab_h   [16];
    logic [2:0] tab_col [16];
    logic       tab_ol  [16];

    exp_t       exp_q[$];
    exp_t       cur;
    logic [7:0] log_x[$];
    logic [6:0] log_y[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    rect_sequence_drawer_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .IDX_W(4)) b ();
    rect_sequence_drawer_if #(.X_W(8), .Y_W(7), .COLOUR_W(7), .IDX_W(1)) b1 ();

    assign b.start       = start0;
    assign b.desc_x0     = tab_x0[b.desc_idx];
    assign b.desc_y0     = tab_y0[b.desc_idx];
    assign b.desc_w      = tab_w[b.desc_idx];
    assign b.desc_h      = tab_h[b.desc_idx];
    assign b.desc_colour = tab_col[b.desc_idx];

    assign b1.start       = start1;
    assign b1.desc_x0     = 8'd0;
    assign b1.desc_y0     = 7'd0;
    assign b1.desc_w      = 8'd16;
    assign b1.desc_h      = 7'd16;
    assign b1.desc_colour = 7'd100;
`ifdef RECT_OUTLINE_EN
    assign b.desc_outline  = tab_ol[b.desc_idx];
    assign b1.desc_outline = 1'b0;
`endif

    rect_sequence_drawer #(.NUM_RECTS(NR), .X_W(8), .Y_W(7), .COLOUR_W(3), .IDX_W(4)) u0 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (b)
    );

    rect_sequence_drawer #(.NUM_RECTS(1), .X_W(8), .Y_W(7), .COLOUR_W(7), .IDX_W(1)) u1 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (b1)
    );

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic set_rect(input int i, input int x0, input int y0, input int w,
                            input int h, input int col, input bit ol);
        tab_x0[i]  = 8'(x0);
        tab_y0[i]  = 7'(y0);
        tab_w[i]   = 8'(w);
        tab_h[i]   = 7'(h);
        tab_col[i] = 3'(col);
        tab_ol[i]  = ol;
    endtask

    // Expected per-cycle outputs from LOAD of rect 0 through the IDLE after DONE.
    function automatic int model_push();
        int   n = 0;
        int   wi, hi;
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            wi = int'(tab_w[i]);
            hi = int'(tab_h[i]);
            e = '0; e.busy = 1'b1; e.idx = 4'(i);
            exp_q.push_back(e); n++;
            for (int r = 0; r < hi; r++) begin
                for (int c = 0; c < wi; c++) begin
                    e = '0; e.busy = 1'b1; e.idx = 4'(i);
                    e.plot   = !tab_ol[i] || r == 0 || c == 0 || r == hi - 1 || c == wi - 1;
                    e.x      = 8'(int'(tab_x0[i]) + c);
                    e.y      = 7'(int'(tab_y0[i]) + r);
                    e.colour = tab_col[i];
                    exp_q.push_back(e); n++;
                end
            end
            e = '0; e.busy = 1'b1; e.idx = 4'(i);
            exp_q.push_back(e); n++;
        end
        e = '0; e.busy = 1'b1; e.finish = 1'b1; e.idx = 4'(NR - 1);
        exp_q.push_back(e); n++;
        e = '0; e.idx = 4'(NR - 1);
        exp_q.push_back(e);
        return n;
    endfunction

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (b.plot !== cur.plot || b.busy !== cur.busy || b.finish !== cur.finish ||
                b.desc_idx !== cur.idx ||
                (cur.plot && (b.x !== cur.x || b.y !== cur.y || b.colour !== cur.colour))) begin
                errors++;
                $display("FAIL stream: got plot=%0d x=%0d y=%0d col=%0d busy=%0d fin=%0d idx=%0d, want plot=%0d x=%0d y=%0d col=%0d busy=%0d fin=%0d idx=%0d",
                         b.plot, b.x, b.y, b.colour, b.busy, b.finish, b.desc_idx,
                         cur.plot, cur.x, cur.y, cur.colour, cur.busy, cur.finish, cur.idx);
            end
            if (b.plot === 1'b1) begin
                log_x.push_back(b.x);
                log_y.push_back(b.y);
            end
        end
    end

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expected cycles left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // hold keeps start high through DONE; poke pulses start in cycle 2 and in DONE.
    task automatic run_seq(input bit hold, input bit poke);
        int len;
        log_x.delete();
        log_y.delete();
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock); #1;
        start0 = hold;
        len = model_push();
        for (int c = 1; c <= len; c++) begin
            if (poke) start0 = (c == 2 || c == len);
            @(posedge clock); #1;
        end
        if (!hold) start0 = 1'b0;
        if (hold) begin
            @(posedge clock); #1;
            start0 = 1'b0;
            void'(model_push());
        end
        drain();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_plot"},   int'(b.plot),     0);
        chk({tag, "_x"},      int'(b.x),        0);
        chk({tag, "_y"},      int'(b.y),        0);
        chk({tag, "_colour"}, int'(b.colour),   0);
        chk({tag, "_busy"},   int'(b.busy),     0);
        chk({tag, "_finish"}, int'(b.finish),   0);
        chk({tag, "_idx"},    int'(b.desc_idx), 0);
    endtask

    task automatic run_single();
        int plots = 0, fins = 0, c_load = -1, c_fin = -1;
        int fx = -1, fy = -1, fc = -1, lx = -1, ly = -1;
        @(negedge clock);
        start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clock);
            if (b1.busy === 1'b1 && c_load < 0) c_load = c;
            if (b1.plot === 1'b1) begin
                if (plots == 0) begin
                    fx = int'(b1.x); fy = int'(b1.y); fc = int'(b1.colour);
                end
                lx = int'(b1.x);
                ly = int'(b1.y);
                plots++;
            end
            if (b1.finish === 1'b1) begin
                fins++;
                c_fin = c;
            end
            @(posedge clock);
        end
        chk("single_plots", plots, 256);
        chk("single_first_x", fx, 0);
        chk("single_first_y", fy, 0);
        chk("single_colour", fc, 100);
        chk("single_last_x", lx, 15);
        chk("single_last_y", ly, 15);
        chk("single_finish_count", fins, 1);
        chk("single_finish_delay", c_fin - c_load, 258);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) set_rect(i, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check_reset("reset");
        chk("reset_u1_busy", int'(b1.busy), 0);
        @(negedge clock);
        resetn = 1'b1;

        run_single();

        // Wrap in both axes, a zero-width rect and a zero-height rect.
        set_rect(0, 254, 126, 4, 2, 6, 1'b0);
        set_rect(1, 9, 9, 0, 3, 1, 1'b0);
        set_rect(2, 5, 5, 1, 1, 2, 1'b0);
        set_rect(3, 7, 7, 3, 0, 3, 1'b0);
        run_seq(1'b0, 1'b1);
        chk("wrap_plot_count", log_x.size(), 9);
        if (log_x.size() == 9) begin
            chk("wrap_x0", int'(log_x[0]), 254);
            chk("wrap_x1", int'(log_x[1]), 255);
            chk("wrap_x2", int'(log_x[2]), 0);
            chk("wrap_x3", int'(log_x[3]), 1);
            chk("wrap_y_row0", int'(log_y[0]), 126);
            chk("wrap_y_row1", int'(log_y[4]), 127);
            chk("skip_next_x", int'(log_x[8]), 5);
        end

        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < NR; i++)
                set_rect(i, $urandom_range(0, 255), $urandom_range(0, 127),
                         $urandom_range(0, 5), $urandom_range(0, 4),
                         $urandom_range(0, 7), 1'b0);
            run_seq(1'b0, s[0]);
        end

        for (int i = 0; i < NR; i++)
            set_rect(i, $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 7), 1'b0);
        run_seq(1'b1, 1'b0);

        // Reset in the middle of rect 2: cycles 1-12 cover rects 0/1, rect 2 LOAD is 13.
        set_rect(0, 10, 10, 2, 2, 1, 1'b0);
        set_rect(1, 20, 20, 2, 2, 2, 1'b0);
        set_rect(2, 30, 30, 4, 4, 3, 1'b0);
        set_rect(3, 0, 0, 1, 1, 4, 1'b0);
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock); #1;
        start0 = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        chk("mid_draw_plot", int'(b.plot), 1);
        chk("mid_draw_idx", int'(b.desc_idx), 2);
        chk("mid_draw_x", int'(b.x), 32);
        #2;
        resetn = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        run_seq(1'b0, 1'b0);

`ifdef RECT_OUTLINE_EN
        set_rect(0, 40, 20, 4, 3, 5, 1'b1);
        set_rect(1, 0, 0, 0, 0, 0, 1'b0);
        set_rect(2, 0, 0, 0, 0, 0, 1'b0);
        set_rect(3, 0, 0, 0, 0, 0, 1'b0);
        run_seq(1'b0, 1'b0);
        chk("outline_plots", log_x.size(), 10);
        begin
            int interior = 0;
            for (int k = 0; k < log_x.size(); k++)
                if (log_y[k] == 7'd21 && (log_x[k] == 8'd41 || log_x[k] == 8'd42)) interior++;
            chk("outline_interior", interior, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rect_sequence_drawer.md
Name: rect_sequence_drawer

Overview:
Parametrised successor to the fixed-screen drawing blocks. On a start pulse it walks a table of NUM_RECTS rectangle descriptors. For each descriptor it emits a row-major pixel stream (plot/x/y/colour) to the VGA adapter, then pulses finish. Descriptors come from an external table indexed by desc_idx, so screens such as the entrance, game-over and level banner share one drawer and differ only in their table.

Parameters:
NUM_RECTS, 4, number of descriptors drawn per sequence (1..16)
X_W, 8, x coordinate and width bit count
Y_W, 7, y coordinate and height bit count
COLOUR_W, 3, colour bit count
IDX_W, 4, descriptor index width; must satisfy 2^IDX_W >= NUM_RECTS

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin a sequence; sampled only in IDLE
desc_idx  out  IDX_W  index of the descriptor currently requested
desc_x0  in  X_W  left edge of descriptor desc_idx
desc_y0  in  Y_W  top edge
desc_w  in  X_W  width in pixels; 0 means skip
desc_h  in  Y_W  height in pixels; 0 means skip
desc_colour  in  COLOUR_W  fill colour
plot  out  1  pixel valid this cycle
x  out  X_W  pixel x
y  out  Y_W  pixel y
colour  out  COLOUR_W  pixel colour
busy  out  1  high from LOAD through DONE inclusive
finish  out  1  one-cycle pulse in DONE

Behaviour:
- One clock domain. Reset is asynchronous, active-low (resetn); all state is on the rising edge of clock.
- Reset values: state=IDLE, desc_idx=0, plot=0, x=0, y=0, colour=0, busy=0, finish=0, pixel counters=0.
- Reset asserted mid-sequence aborts immediately, with no further plot. The next sequence restarts at descriptor 0.
- States: IDLE, LOAD, DRAW, NEXT, DONE.
- IDLE: start=1 -> LOAD, desc_idx=0. start=0 -> stay.
- LOAD, 1 cycle: register desc_x0/y0/w/h/colour and clear dx, dy.
  - w==0 or h==0 -> NEXT, no pixels drawn.
  - Otherwise -> DRAW.
- DRAW: each cycle output plot=1, x=x0+dx, y=y0+dy, colour=registered colour.
  - Sums are truncated modulo 2^X_W / 2^Y_W; wrap is allowed and is not an error.
  - dx increments each cycle. On dx==w-1: dx=0 and dy increments.
  - On dx==w-1 and dy==h-1 -> NEXT.
  - Exactly w*h consecutive plot cycles per rectangle, row-major, top-left first.
- NEXT, 1 cycle, plot=0:
  - desc_idx==NUM_RECTS-1 -> DONE.
  - Otherwise desc_idx+1 -> LOAD.
- DONE, 1 cycle: finish=1, busy=1 -> IDLE. desc_idx holds its last value until the next start.
- start is ignored outside IDLE. start held high through DONE begins a new sequence on the first IDLE cycle.
- Descriptor inputs must be stable from the cycle desc_idx changes through LOAD. They are don't-care in DRAW.
- Latency: start sampled at edge 0 -> LOAD in cycle 1 -> first plot in cycle 2.
- Total sequence length = sum over rects of (1 + w*h + 1) + 1 cycles.
- plot, x, y and colour are registered together, so they always refer to the same pixel.

Optional Feature:
- Macro RECT_OUTLINE_EN.
- When defined: adds input desc_outline (1 bit), latched in LOAD.
  - desc_outline=1: plot is asserted only on border pixels (dx==0, dx==w-1, dy==0 or dy==h-1).
  - Interior cycles still elapse with plot=0, x/y still advancing, so cycle count is unchanged.
- When undefined: the port is absent and every rectangle is filled.

Decomposition:
- Package rect_draw_pkg: state encoding localparams (IDLE=0..DONE=4), default width constants, SKIP condition helper.
- One sub-module, rect_raster_counter: a dx/dy raster counter with load, enable and last-pixel flag, parametrised on X_W/Y_W.
- The top level holds the FSM, descriptor registers and output registers.

Test Plan:
- Reset then start with rect0 (x0=0, y0=0, w=16, h=16, colour=100) and NUM_RECTS=1 -> 256 plot cycles, first (0,0), last (15,15); finish pulses exactly once, 258 cycles after LOAD.
- Four rects, rect1 with w=0 -> rect1 produces no plot, only LOAD+NEXT; other rects are drawn in index order; desc_idx sequence is 0,1,2,3.
- Wrap: x0=254, w=4, y0=126, h=2 -> x sequence 254,255,0,1 and y values 126 and 127, no error.
- start pulsed during DRAW and DONE -> ignored, no restart; a start held high through DONE begins a new sequence in the following IDLE cycle.
- resetn dropped mid-DRAW of rect2 -> plot=0 asynchronously, all outputs at reset values; the next start draws from rect0.
- With RECT_OUTLINE_EN, w=4, h=3, outline=1 -> 10 plot cycles (border only) over 12 DRAW cycles; pixels (1,1) and (2,1) are not plotted.
